shift_reg_ctrl: RTL and testbench

Command sequencer for the 8-bit universal shift register (select 00 hold, 01 shift right with MSB serial-in, 10 shift left with LSB serial-in, 11 parallel load). It accepts one command at a time over a valid/ready handshake and drives the register's select, parallel and serial inputs for the required number of cycles. It supports multi-bit logical, arithmetic and rotate shifts, loads and clears, and signals completion with a one-cycle done pulse. It sits between a register-file or bus front end and the shift register instance.

---
 rtl/shift_reg_ctrl.sv | 136 +++++++++++++
 tb/tb_shift_reg_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/shift_reg_ctrl.sv
// Command sequencer for an 8-bit universal shift register.
// Accepts one command at a time and drives select/parallel/serial inputs until the result is in sr_q.
module shift_reg_ctrl #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       sr_select,
  output logic [WIDTH-1:0] sr_in,
  output logic             sr_msb_in,
  output logic             sr_lsb_in,
  output logic             sr_clear,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_SHL   = 3'b011;
  localparam logic [2:0] OP_ROR   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  logic [2:0]       r_state;
  logic [2:0]       r_op;
  logic             r_fill;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;

  logic [2:0]       w_next_state;
  logic [AMT_W-1:0] w_amt;
  logic             w_accept;
  logic             w_unused_q;

  // Only the end bits of sr_q feed back into the serial inputs.
  assign w_unused_q = ^sr_q[WIDTH-2:1];

  assign cmd_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_amt     = (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_NOP:   w_next_state = S_DONE;
            OP_LOAD:  w_next_state = S_LOAD;
            OP_CLEAR: w_next_state = S_CLEAR;
            default:  w_next_state = (w_amt == '0) ? S_DONE : S_SHIFT;
          endcase
        end
      end
      S_LOAD:  w_next_state = S_DONE;
      S_CLEAR: w_next_state = S_DONE;
      S_SHIFT: w_next_state = (r_cnt == AMT_W'(1)) ? S_DONE : S_SHIFT;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_fill  <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_fill <= cmd_fill;
        r_data <= cmd_data;
        r_cnt  <= w_amt;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt - AMT_W'(1);
      end
    end
  end

  // Serial feedback is taken combinationally from sr_q so every step of a rotate/ASR sees the latest value.
  always_comb begin
    sr_select = SEL_HOLD;
    sr_in     = '0;
    sr_msb_in = 1'b0;
    sr_lsb_in = 1'b0;
    sr_clear  = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_LOAD: begin
        sr_select = SEL_LOAD;
        sr_in     = r_data;
      end
      S_CLEAR: sr_clear = 1'b1;
      S_SHIFT: begin
        case (r_op)
          OP_SHR: begin sr_select = SEL_RIGHT; sr_msb_in = r_fill;         end
          OP_ROR: begin sr_select = SEL_RIGHT; sr_msb_in = sr_q[0];        end
          OP_ASR: begin sr_select = SEL_RIGHT; sr_msb_in = sr_q[WIDTH-1];  end
          OP_SHL: begin sr_select = SEL_LEFT;  sr_lsb_in = r_fill;         end
          OP_ROL: begin sr_select = SEL_LEFT;  sr_lsb_in = sr_q[WIDTH-1];  end
          default: sr_select = SEL_HOLD;
        endcase
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl, with a behavioural universal shift register closing the loop.
module tb_shift_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_amt;
  logic [7:0] cmd_data;
  logic       cmd_fill;
  logic [7:0] sr_q;
  logic [1:0] sr_select;
  logic [7:0] sr_in;
  logic       sr_msb_in;
  logic       sr_lsb_in;
  logic       sr_clear;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .sr_q(sr_q), .sr_select(sr_select), .sr_in(sr_in),
    .sr_msb_in(sr_msb_in), .sr_lsb_in(sr_lsb_in), .sr_clear(sr_clear),
    .busy(busy), .done(done)
  );

  // Universal shift register; its reset is reset OR sr_clear as at the top level.
  always_ff @(posedge clk) begin
    if (reset || sr_clear) sr_q <= 8'h00;
    else begin
      case (sr_select)
        2'b01:   sr_q <= {sr_msb_in, sr_q[7:1]};
        2'b10:   sr_q <= {sr_q[6:0], sr_lsb_in};
        2'b11:   sr_q <= sr_in;
        default: sr_q <= sr_q;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts and ends on a falling edge; scrambles cmd_* after accept.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] amt,
                         input logic [7:0] data, input logic fill, input int exp_done,
                         input logic [1:0] exp_sel, input int exp_clr, input logic [7:0] exp_q);
    int  cyc;
    int  bad;
    int  clr;
    bit  seen;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    cmd_fill  = fill;
    check_eq({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_amt   = ~amt;
    cmd_data  = ~data;
    cmd_fill  = ~fill;
    cyc = 0; bad = 0; clr = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (sr_clear) clr++;
      if (done) begin
        seen = 1'b1;
        if (sr_select !== 2'b00) bad++;
      end else if (sr_select !== exp_sel || busy !== 1'b1) bad++;
    end
    check_eq({tag, ".done_cyc"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_done));
    check_eq({tag, ".q"}, 32'(sr_q), 32'(exp_q));
    check_eq({tag, ".sel_bad"}, 32'(bad), 32'd0);
    check_eq({tag, ".clr"}, 32'(clr), 32'(exp_clr));
    @(negedge clk);
    check_eq({tag, ".idle"}, {30'd0, cmd_ready, busy}, 32'h2);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_amt = 4'd0; cmd_data = 8'h00; cmd_fill = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.ready", 32'(cmd_ready), 32'd0);
    check_eq("rst.drv", {20'd0, sr_select, sr_in, sr_msb_in, sr_lsb_in}, 32'd0);
    check_eq("rst.clr", 32'(sr_clear), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rst.ready_after", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    run_cmd("load_a5",  3'b001, 4'd0,  8'hA5, 1'b0, 2, 2'b11, 0, 8'hA5);
    run_cmd("ror3",     3'b100, 4'd3,  8'h00, 1'b0, 4, 2'b01, 0, 8'hB4);
    run_cmd("load_0f",  3'b001, 4'd0,  8'h0F, 1'b0, 2, 2'b11, 0, 8'h0F);
    run_cmd("shl12",    3'b011, 4'd12, 8'h00, 1'b1, 9, 2'b10, 0, 8'hFF);
    run_cmd("load_80",  3'b001, 4'd0,  8'h80, 1'b0, 2, 2'b11, 0, 8'h80);
    run_cmd("asr2",     3'b110, 4'd2,  8'h00, 1'b0, 3, 2'b01, 0, 8'hE0);
    run_cmd("rol8",     3'b101, 4'd8,  8'h00, 1'b0, 9, 2'b10, 0, 8'hE0);
    run_cmd("shr0",     3'b010, 4'd0,  8'h00, 1'b1, 1, 2'b00, 0, 8'hE0);
    run_cmd("nop",      3'b000, 4'd5,  8'h33, 1'b1, 1, 2'b00, 0, 8'hE0);
    run_cmd("clear",    3'b111, 4'd5,  8'h33, 1'b1, 2, 2'b00, 1, 8'h00);
    run_cmd("load_c3",  3'b001, 4'd0,  8'hC3, 1'b0, 2, 2'b11, 0, 8'hC3);
    run_cmd("shr2f1",   3'b010, 4'd2,  8'h00, 1'b1, 3, 2'b01, 0, 8'hF0);
    run_cmd("shl1f0",   3'b011, 4'd1,  8'h00, 1'b0, 2, 2'b10, 0, 8'hE0);
    run_cmd("load_3c",  3'b001, 4'd0,  8'h3C, 1'b0, 2, 2'b11, 0, 8'h3C);

    // Reset lands in cycle 3 of an 8-step rotate while a LOAD waits on cmd_valid.
    cmd_valid = 1'b1; cmd_op = 3'b100; cmd_amt = 4'd8; cmd_data = 8'h00; cmd_fill = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rr.sel_c3", 32'(sr_select), 32'h1);
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_amt = 4'd0; cmd_data = 8'h5A;
    #1;
    check_eq("rr.ready_in_rst", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check_eq("rr.sel", 32'(sr_select), 32'd0);
    check_eq("rr.busy", 32'(busy), 32'd0);
    check_eq("rr.done", 32'(done), 32'd0);
    check_eq("rr.q", 32'(sr_q), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rr.ready_rel", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("rr.load_sel", 32'(sr_select), 32'h3);
    @(negedge clk);
    check_eq("rr.load_done", 32'(done), 32'd1);
    check_eq("rr.load_q", 32'(sr_q), 32'h5A);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
